alarm_ringer: RTL and testbench

ALARM_RINGER -- requirements
Module: alarm_ringer

---
 rtl/alarm_ringer.sv | 149 ++++++++++++++
 tb/tb_alarm_ringer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings a gated tone on a rising alarm match, with snooze, stop
// key, mute switch and bounded ring/snooze durations counted in whole seconds.
module alarm_ringer #(
  parameter int CLK_HZ     = 50000000,
  parameter int TONE_HZ    = 1000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       SW5,
  output logic       BUZZ,
  output logic       LED,
  output logic       RINGING,
  output logic       SNOOZED,
  output logic [3:0] SNZ_CNT
);

  localparam int HALF = CLK_HZ / 2;
  localparam int TDIV = CLK_HZ / (2 * TONE_HZ);
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TW   = (TDIV > 1) ? $clog2(TDIV) : 1;

  localparam logic [9:0] RING_T  = 10'(RING_SEC);
  localparam logic [9:0] SNZ_T   = 10'(SNOOZE_SEC);
  localparam logic [3:0] MAX_SNZ = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    timer_q, timer_d;
  logic [3:0]    snz_q, snz_d;
  logic          presc_clr;
  logic [PW-1:0] pcnt_q;
  logic          half_q;
  logic [TW-1:0] tcnt_q;
  logic          tone_q;
  logic [1:0]    k0_sync_q, k1_sync_q;
  logic          k0_last_q, k1_last_q;
  logic          en_q;
  logic          key0_pulse, key1_pulse;
  logic          half_tick, sec_tick;

  assign key0_pulse = k0_sync_q[1] & ~k0_last_q;
  assign key1_pulse = k1_sync_q[1] & ~k1_last_q;
  assign half_tick  = (pcnt_q == PW'(HALF - 1));
  assign sec_tick   = half_tick & half_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      snz_q     <= '0;
      pcnt_q    <= '0;
      half_q    <= 1'b0;
      tcnt_q    <= '0;
      tone_q    <= 1'b0;
      k0_sync_q <= '0;
      k1_sync_q <= '0;
      k0_last_q <= 1'b0;
      k1_last_q <= 1'b0;
      // Preset high so a match already active at reset release is not an edge.
      en_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      snz_q     <= snz_d;
      k0_sync_q <= {k0_sync_q[0], KEY0};
      k1_sync_q <= {k1_sync_q[0], KEY1};
      k0_last_q <= k0_sync_q[1];
      k1_last_q <= k1_sync_q[1];
      en_q      <= ENABLE;
      if (presc_clr) begin
        pcnt_q <= '0;
        half_q <= 1'b0;
      end else if (half_tick) begin
        pcnt_q <= '0;
        half_q <= ~half_q;
      end else begin
        pcnt_q <= pcnt_q + PW'(1);
      end
      if (tcnt_q == TW'(TDIV - 1)) begin
        tcnt_q <= '0;
        tone_q <= ~tone_q;
      end else begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    snz_d     = snz_q;
    presc_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ENABLE && !en_q) begin
          state_d   = S_RING;
          timer_d   = RING_T;
          snz_d     = '0;
          presc_clr = 1'b1;
        end
      end
      S_RING: begin
        // Stop key beats expiry, expiry beats snooze.
        if (key0_pulse) begin
          state_d = S_DONE;
        end else if (sec_tick && timer_q == 10'd1) begin
          state_d = S_DONE;
        end else if (key1_pulse && snz_q < MAX_SNZ) begin
          state_d   = S_SNOOZE;
          snz_d     = snz_q + 4'd1;
          timer_d   = SNZ_T;
          presc_clr = 1'b1;
        end else if (sec_tick) begin
          timer_d = timer_q - 10'd1;
        end
      end
      S_SNOOZE: begin
        if (key0_pulse) begin
          state_d = S_DONE;
        end else if (sec_tick && timer_q == 10'd1) begin
          state_d   = S_RING;
          timer_d   = RING_T;
          presc_clr = 1'b1;
        end else if (sec_tick) begin
          timer_d = timer_q - 10'd1;
        end
      end
      S_DONE: begin
        if (!ENABLE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beep is on during the first half of every second, i.e. while half_q is low.
  assign RINGING = (state_q == S_RING);
  assign SNOOZED = (state_q == S_SNOOZE);
  assign LED     = RINGING & ~half_q;
  assign BUZZ    = LED & tone_q & ~SW5;
  assign SNZ_CNT = snz_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios plus random traffic, all checked
// cycle by cycle against a time-based behavioural model of the alarm.
module tb_alarm_ringer;

  localparam int CLK_HZ = 20, TONE_HZ = 5, RING_SEC = 3, SNOOZE_SEC = 2, MAX_SNOOZE = 2;
  localparam int HALF     = CLK_HZ / 2;
  localparam int TDIV     = CLK_HZ / (2 * TONE_HZ);
  localparam int RING_DUR = RING_SEC * CLK_HZ;
  localparam int SNZ_DUR  = SNOOZE_SEC * CLK_HZ;

  logic       clk;
  logic       RST, ENABLE, KEY0, KEY1, SW5;
  logic       BUZZ, LED, RINGING, SNOOZED;
  logic [3:0] SNZ_CNT;

  int errors = 0;
  int checks = 0;

  alarm_ringer #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .CLK(clk), .RST(RST), .ENABLE(ENABLE), .KEY0(KEY0), .KEY1(KEY1), .SW5(SW5),
    .BUZZ(BUZZ), .LED(LED), .RINGING(RINGING), .SNOOZED(SNOOZED), .SNZ_CNT(SNZ_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: 0 idle, 1 ring, 2 snooze, 3 done. Time is kept as cycles
  // elapsed since entering ring/snooze and since the last reset edge.
  int       m_st = 0, m_age = 0, m_snz = 0, m_rst_age = 0;
  bit       m_en_prev = 1'b1;
  bit [2:0] h0 = '0, h1 = '0;

  task automatic model_edge();
    bit p0, p1;
    // A key takes effect when it was first seen high two edges ago.
    p0 = h0[1] & ~h0[2];
    p1 = h1[1] & ~h1[2];
    if (RST) begin
      m_st = 0; m_age = 0; m_snz = 0; m_en_prev = 1'b1;
      h0 = '0; h1 = '0; m_rst_age = 0;
      return;
    end
    case (m_st)
      0: if (ENABLE && !m_en_prev) begin m_st = 1; m_age = 0; m_snz = 0; end
      1: begin
        if (p0) m_st = 3;
        else if (m_age + 1 == RING_DUR) m_st = 3;
        else if (p1 && m_snz < MAX_SNOOZE) begin m_st = 2; m_snz++; m_age = 0; end
        else m_age++;
      end
      2: begin
        if (p0) m_st = 3;
        else if (m_age + 1 == SNZ_DUR) begin m_st = 1; m_age = 0; end
        else m_age++;
      end
      default: if (!ENABLE) m_st = 0;
    endcase
    m_en_prev = ENABLE;
    h0 = {h0[1:0], KEY0};
    h1 = {h1[1:0], KEY1};
    m_rst_age++;
  endtask

  function automatic logic [7:0] exp_vec();
    logic ring, led, tone;
    ring = (m_st == 1);
    led  = ring && ((m_age / HALF) % 2 == 0);
    tone = ((m_rst_age / TDIV) % 2) == 1;
    return {led && tone && !SW5, led, ring, m_st == 2, 4'(m_snz)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {BUZZ, LED, RINGING, SNOOZED, SNZ_CNT};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int ring_cnt = 0;
    RST = 1'b1; ENABLE = 1'b1; KEY0 = 1'b0; KEY1 = 1'b0; SW5 = 1'b0;
    step(); step();
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 8'h00);
    end
    RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_release i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (RINGING) ring_cnt++;
    end
    checks++;
    if (ring_cnt !== 0) begin
      errors++; $display("FAIL reset_no_trigger ring_cycles=%0d exp=0", ring_cnt);
    end
    ENABLE = 1'b0;
    step(); step();
  endtask

  task automatic test_ring_timeout();
    int ring_cnt = 0, led_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      ENABLE = (i < 90) || (i >= 95 && i < 106);
      KEY0   = (i >= 100 && i < 104);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i < 90 && RINGING) ring_cnt++;
      if (i < 90 && LED) led_cnt++;
      if (i == 99) begin
        checks++;
        if (RINGING !== 1'b1) begin
          errors++; $display("FAIL retrigger ringing=%b exp=1", RINGING);
        end
      end
    end
    KEY0 = 1'b0;
    checks++;
    if (ring_cnt !== RING_DUR) begin
      errors++; $display("FAIL ring_length got=%0d exp=%0d", ring_cnt, RING_DUR);
    end
    checks++;
    if (led_cnt !== RING_DUR / 2) begin
      errors++; $display("FAIL led_length got=%0d exp=%0d", led_cnt, RING_DUR / 2);
    end
  endtask

  task automatic test_snooze();
    int snz_cyc = 0, ring_cnt = 0;
    bit prev_snz = 1'b0;
    for (int i = 0; i < 120; i++) begin
      ENABLE = (i < 115);
      KEY1   = (i >= 10 && i < 14);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL snooze i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (SNOOZED) begin
        snz_cyc++;
        checks++;
        if (SNZ_CNT !== 4'd1) begin
          errors++; $display("FAIL snooze_count i=%0d got=%0d exp=1", i, SNZ_CNT);
        end
      end
      if (RINGING) ring_cnt++;
      if (prev_snz && !SNOOZED) begin
        checks++;
        if (RINGING !== 1'b1) begin
          errors++; $display("FAIL snooze_rering i=%0d ringing=%b exp=1", i, RINGING);
        end
      end
      prev_snz = SNOOZED;
    end
    KEY1 = 1'b0;
    checks++;
    if (snz_cyc !== SNZ_DUR) begin
      errors++; $display("FAIL snooze_length got=%0d exp=%0d", snz_cyc, SNZ_DUR);
    end
    checks++;
    if (ring_cnt !== 12 + RING_DUR) begin
      errors++; $display("FAIL snooze_ring_total got=%0d exp=%0d", ring_cnt, 12 + RING_DUR);
    end
  endtask

  task automatic test_snooze_limit();
    for (int i = 0; i < 130; i++) begin
      ENABLE = (i < 125);
      KEY1   = (i >= 5 && i < 9) || (i >= 60 && i < 64) || (i >= 110 && i < 114);
      KEY0   = (i >= 120 && i < 124);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL limit i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i == 115) begin
        checks++;
        if (SNZ_CNT !== 4'd2 || RINGING !== 1'b1) begin
          errors++; $display("FAIL limit_third got cnt=%0d ring=%b exp cnt=2 ring=1", SNZ_CNT, RINGING);
        end
      end
    end
    KEY0 = 1'b0; KEY1 = 1'b0;
  endtask

  task automatic test_priority();
    for (int i = 0; i < 30; i++) begin
      ENABLE = (i < 25);
      KEY0   = (i >= 5 && i < 9);
      KEY1   = (i >= 5 && i < 9);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL priority i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i == 10) begin
        checks++;
        if (RINGING !== 1'b0 || SNOOZED !== 1'b0 || SNZ_CNT !== 4'd0) begin
          errors++; $display("FAIL priority_done got r=%b s=%b c=%0d exp r=0 s=0 c=0", RINGING, SNOOZED, SNZ_CNT);
        end
      end
    end
    KEY0 = 1'b0; KEY1 = 1'b0;
  endtask

  task automatic test_mute();
    int ring_cnt = 0, led_cnt = 0, buzz_cnt = 0;
    SW5 = 1'b1;
    for (int i = 0; i < 75; i++) begin
      ENABLE = (i < 70);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL mute i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (RINGING) ring_cnt++;
      if (LED) led_cnt++;
      if (BUZZ) buzz_cnt++;
    end
    SW5 = 1'b0;
    checks++;
    if (ring_cnt !== RING_DUR || led_cnt !== RING_DUR / 2 || buzz_cnt !== 0) begin
      errors++; $display("FAIL mute_counts got ring=%0d led=%0d buzz=%0d exp ring=%0d led=%0d buzz=0",
                         ring_cnt, led_cnt, buzz_cnt, RING_DUR, RING_DUR / 2);
    end
  endtask

  task automatic test_reset_mid_snooze();
    int ring_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      ENABLE = 1'b1;
      KEY1   = (i >= 5 && i < 9);
      RST    = (i == 20);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_snooze i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i == 19) begin
        checks++;
        if (SNOOZED !== 1'b1) begin
          errors++; $display("FAIL rst_snooze_pre snoozed=%b exp=1", SNOOZED);
        end
      end
      if (i == 20) begin
        checks++;
        if (dut_vec() !== 8'h00) begin
          errors++; $display("FAIL rst_snooze_clear got=%h exp=%h", dut_vec(), 8'h00);
        end
      end
      if (i > 20 && RINGING) ring_cnt++;
    end
    RST = 1'b0; KEY1 = 1'b0;
    checks++;
    if (ring_cnt !== 0) begin
      errors++; $display("FAIL rst_snooze_idle ring_cycles=%0d exp=0", ring_cnt);
    end
    ENABLE = 1'b0;
    step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) ENABLE = ~ENABLE;
      if ($urandom_range(0, 39) == 0) KEY0 = ~KEY0;
      if ($urandom_range(0, 19) == 0) KEY1 = ~KEY1;
      if ($urandom_range(0, 49) == 0) SW5 = ~SW5;
      RST = ($urandom_range(0, 799) == 0);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_snooze_limit();
    test_priority();
    test_mute();
    test_reset_mid_snooze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
